// File: rtl/cic_decimator_if.sv
// cic_decimator_if: sample-stream bundle between the CORDIC mixer and the
// CIC decimator. The master drives rate and input samples; the slave (the
// decimator) returns the decimated samples and their strobe.
interface cic_decimator_if #(
   parameter int IN_WIDTH   = 20,
   parameter int OUT_WIDTH  = 20,
   parameter int RATE_WIDTH = 8
);
   logic [RATE_WIDTH-1:0]        rate;
   logic                         strobe_in;
   logic signed [IN_WIDTH-1:0]   i_in;
   logic signed [IN_WIDTH-1:0]   q_in;
   logic                         strobe_out;
   logic signed [OUT_WIDTH-1:0]  i_out;
   logic signed [OUT_WIDTH-1:0]  q_out;

   modport master (
      output rate, strobe_in, i_in, q_in,
      input  strobe_out, i_out, q_out
   );

   modport slave (
      input  rate, strobe_in, i_in, q_in,
      output strobe_out, i_out, q_out
   );
endinterface

// File: rtl/cic_decimator.sv
// cic_decimator: dual-channel (I/Q) CIC decimator with STAGES pipelined
// integrators and STAGES pipelined combs (M = 1), run-time decimation ratio
// and power-of-two gain normalisation.
// Optional build macro CIC_ROUND_EN: round half-up and saturate the output,
// adding one clock of latency; without it the output is plainly truncated.
module cic_decimator #(
   parameter int IN_WIDTH   = 20,
   parameter int OUT_WIDTH  = 20,
   parameter int STAGES     = 4,
   parameter int RATE_WIDTH = 8
) (
   input  logic           clk,
   input  logic           reset,
   cic_decimator_if.slave bus
);
   localparam int ACC_WIDTH = IN_WIDTH + STAGES*RATE_WIDTH;
   localparam int SHW       = $clog2(STAGES*RATE_WIDTH + 1);
`ifdef CIC_ROUND_EN
   localparam int NPIPE     = STAGES + 2;
`else
   localparam int NPIPE     = STAGES + 1;
`endif

   logic [RATE_WIDTH-1:0]        w_rate_eff;
   logic [RATE_WIDTH-1:0]        r_rate_q;
   logic [RATE_WIDTH-1:0]        r_count;
   logic [SHW-1:0]               r_shift;
   logic [SHW-1:0]               r_sh [STAGES+1];
   logic                         r_dec;
   logic [NPIPE-1:0]             r_en;
   logic [STAGES-1:0]            w_comb_en;
   int                           w_lo;
   logic signed [ACC_WIDTH-1:0]  w_in    [2];
   logic signed [ACC_WIDTH-1:0]  r_integ [2][STAGES];
   logic signed [ACC_WIDTH-1:0]  r_comb  [2][STAGES];
   logic signed [ACC_WIDTH-1:0]  r_dly   [2][STAGES];
   logic signed [OUT_WIDTH-1:0]  r_out   [2];

   // Gain shift STAGES*ceil(log2 r): index of the top set bit of r-1, plus one.
   function automatic logic [SHW-1:0] f_shift(input logic [RATE_WIDTH-1:0] r);
      logic [RATE_WIDTH-1:0] m;
      int unsigned           lg;
      m  = r - 1'b1;
      lg = 0;
      for (int unsigned b = 0; b < RATE_WIDTH; b++)
         if (m[b]) lg = b + 1;
      return SHW'(STAGES * lg);
   endfunction

   // Clamp the requested ratio to a minimum of 2 and sign-extend inputs.
   always_comb begin
      w_rate_eff = (bus.rate < RATE_WIDTH'(2)) ? RATE_WIDTH'(2) : bus.rate;
      w_in[0] = {{(ACC_WIDTH-IN_WIDTH){bus.i_in[IN_WIDTH-1]}}, bus.i_in};
      w_in[1] = {{(ACC_WIDTH-IN_WIDTH){bus.q_in[IN_WIDTH-1]}}, bus.q_in};
   end

   // Decimation counter; the ratio and its gain shift reload at each block boundary.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count  <= '0;
         r_dec    <= 1'b0;
         r_rate_q <= w_rate_eff;
         r_shift  <= f_shift(w_rate_eff);
      end else begin
         r_dec <= 1'b0;
         if (bus.strobe_in) begin
            if (r_count == r_rate_q - 1'b1) begin
               r_count  <= '0;
               r_dec    <= 1'b1;
               r_rate_q <= w_rate_eff;
               r_shift  <= f_shift(w_rate_eff);
            end else begin
               r_count <= r_count + 1'b1;
            end
         end
      end
   end

   // Strobe pipe and shift pipe advance every clock so a block's gain shift
   // travels with its samples even when the next block reloads r_shift early.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_en <= '0;
         for (int unsigned k = 0; k < STAGES + 1; k++) r_sh[k] <= '0;
      end else begin
         r_en    <= {r_en[NPIPE-2:0], r_dec};
         r_sh[0] <= r_shift;
         for (int unsigned k = 1; k < STAGES + 1; k++) r_sh[k] <= r_sh[k-1];
      end
   end

   // Per-stage comb enables: stage 0 on the decimation strobe, then one clock per stage.
   always_comb begin
      w_comb_en[0] = r_dec;
      for (int unsigned k = 1; k < STAGES; k++) w_comb_en[k] = r_en[k-1];
      w_lo = IN_WIDTH - OUT_WIDTH + int'(r_sh[STAGES]);
   end

   // Integrator cascade; wrap-around is intentional and cancelled by the combs.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned c = 0; c < 2; c++)
            for (int unsigned k = 0; k < STAGES; k++) r_integ[c][k] <= '0;
      end else if (bus.strobe_in) begin
         for (int unsigned c = 0; c < 2; c++) begin
            r_integ[c][0] <= r_integ[c][0] + w_in[c];
            for (int unsigned k = 1; k < STAGES; k++)
               r_integ[c][k] <= r_integ[c][k] + r_integ[c][k-1];
         end
      end
   end

   // Pipelined comb cascade, one stage per clock behind the decimation strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned c = 0; c < 2; c++)
            for (int unsigned k = 0; k < STAGES; k++) begin
               r_comb[c][k] <= '0;
               r_dly[c][k]  <= '0;
            end
      end else begin
         for (int unsigned c = 0; c < 2; c++)
            for (int unsigned k = 0; k < STAGES; k++)
               if (w_comb_en[k]) begin
                  if (k == 0) begin
                     r_comb[c][k] <= r_integ[c][STAGES-1] - r_dly[c][k];
                     r_dly[c][k]  <= r_integ[c][STAGES-1];
                  end else begin
                     r_comb[c][k] <= r_comb[c][k-1] - r_dly[c][k];
                     r_dly[c][k]  <= r_comb[c][k-1];
                  end
               end
      end
   end

`ifdef CIC_ROUND_EN
   localparam logic signed [ACC_WIDTH:0] C_ONE = (ACC_WIDTH+1)'(1);
   localparam logic signed [ACC_WIDTH:0] C_MAX = {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH:0] C_MIN = {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   logic signed [ACC_WIDTH:0] w_rnd [2];
   logic signed [ACC_WIDTH:0] r_rnd [2];

   // Half-up rounding in one extra bit so the add cannot overflow before saturation.
   always_comb begin
      for (int unsigned c = 0; c < 2; c++)
         w_rnd[c] = ($signed({r_comb[c][STAGES-1][ACC_WIDTH-1], r_comb[c][STAGES-1]})
                     + (C_ONE <<< (w_lo - 1))) >>> w_lo;
   end

   // Register the rounded value, then saturate it into the output register.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned c = 0; c < 2; c++) begin
            r_rnd[c] <= '0;
            r_out[c] <= '0;
         end
      end else begin
         for (int unsigned c = 0; c < 2; c++) begin
            if (r_en[STAGES-1]) r_rnd[c] <= w_rnd[c];
            if (r_en[STAGES])
               r_out[c] <= (r_rnd[c] > C_MAX) ? OUT_WIDTH'(C_MAX) :
                           (r_rnd[c] < C_MIN) ? OUT_WIDTH'(C_MIN) : OUT_WIDTH'(r_rnd[c]);
         end
      end
   end
`else
   // Truncating output slice of the final comb; holds until the next block.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned c = 0; c < 2; c++) r_out[c] <= '0;
      end else if (r_en[STAGES-1]) begin
         for (int unsigned c = 0; c < 2; c++)
            r_out[c] <= OUT_WIDTH'(r_comb[c][STAGES-1] >>> w_lo);
      end
   end
`endif

   assign bus.strobe_out = r_en[NPIPE-1];
   assign bus.i_out      = r_out[0];
   assign bus.q_out      = r_out[1];
endmodule

// File: tb/tb_cic_decimator.sv
// tb_cic_decimator: scoreboard bench for cic_decimator. The reference model
// works in the sample domain with prefix sums and an N-th finite difference on
// the decimated sequence, all modulo 2^ACC, and predicts the exact cycle of
// every output strobe. Build with CIC_ROUND_EN defined for the rounding variant.
module tb_cic_decimator;
   localparam int IW  = 20;
   localparam int OW  = 20;
   localparam int N   = 4;
   localparam int RW  = 8;
   localparam int ACC = IW + N*RW;
`ifdef CIC_ROUND_EN
   localparam int LAT = N + 3;
`else
   localparam int LAT = N + 2;
`endif

   typedef struct {
      int     cyc;
      longint i;
      longint q;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];

   // model state
   longint m_p    [2][N];    // k-fold prefix sums of the input
   longint m_pn   [2][N];    // last N values of the N-fold prefix sum, [0] newest
   longint m_d    [2][N+1];  // decimated sequence history, [0] newest
   int     m_cnt;
   int     m_rblk;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cic_decimator_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .RATE_WIDTH(RW)) bus ();

   cic_decimator #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .STAGES(N), .RATE_WIDTH(RW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string name, input longint act, input longint req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int sat2(input int r);
      return (r < 2) ? 2 : r;
   endfunction

   function automatic int clog2i(input int r);
      int c = 0;
      while ((1 << c) < r) c++;
      return c;
   endfunction

   function automatic longint binom(input int n, input int k);
      longint b = 1;
      for (int j = 1; j <= k; j++) b = b * (n - k + j) / j;
      return b;
   endfunction

   // Scale the wrapped comb result to the output width for ratio r.
   function automatic longint to_out(input longint y, input int r);
      longint v;
      int     lo;
      v  = (y <<< (64 - ACC)) >>> (64 - ACC);
      lo = IW - OW + N * clog2i(r);
`ifdef CIC_ROUND_EN
      v = (v + (longint'(1) <<< (lo - 1))) >>> lo;
      if (v > (longint'(1) <<< (OW - 1)) - 1) v = (longint'(1) <<< (OW - 1)) - 1;
      else if (v < -(longint'(1) <<< (OW - 1))) v = -(longint'(1) <<< (OW - 1));
      return v;
`else
      v = v >>> lo;
      return (v <<< (64 - OW)) >>> (64 - OW);
`endif
   endfunction

   function automatic void model_clear();
      for (int c = 0; c < 2; c++) begin
         for (int k = 0; k < N; k++) begin
            m_p[c][k]  = 0;
            m_pn[c][k] = 0;
         end
         for (int k = 0; k <= N; k++) m_d[c][k] = 0;
      end
      m_cnt = 0;
   endfunction

   function automatic longint rnd_s();
      logic signed [IW-1:0] t;
      t = IW'($urandom);
      return longint'(t);
   endfunction

   // Apply one cycle of stimulus and advance the model to match.
   task automatic drive(input bit rst, input bit stb, input int r, input longint xi, input longint xq);
      longint x [2];
      longint y [2];
      exp_t   e;
      @(negedge clk);
      reset         = rst;
      bus.strobe_in = stb;
      bus.rate      = RW'(r);
      bus.i_in      = IW'(xi);
      bus.q_in      = IW'(xq);
      x[0] = xi;
      x[1] = xq;
      if (rst) begin
         model_clear();
         m_rblk = sat2(r);
         while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
      end else if (stb) begin
         for (int c = 0; c < 2; c++) begin
            m_p[c][0] += x[c];
            for (int k = 1; k < N; k++) m_p[c][k] += m_p[c][k-1];
            for (int k = N - 1; k > 0; k--) m_pn[c][k] = m_pn[c][k-1];
            m_pn[c][0] = m_p[c][N-1];
         end
         m_cnt++;
         if (m_cnt == m_rblk) begin
            for (int c = 0; c < 2; c++) begin
               for (int k = N; k > 0; k--) m_d[c][k] = m_d[c][k-1];
               m_d[c][0] = m_pn[c][N-1];
               y[c] = 0;
               for (int k = 0; k <= N; k++)
                  y[c] += ((k % 2) ? -binom(N, k) : binom(N, k)) * m_d[c][k];
            end
            e.cyc = cyc + LAT;
            e.i   = to_out(y[0], m_rblk);
            e.q   = to_out(y[1], m_rblk);
            sb.push_back(e);
            m_cnt  = 0;
            m_rblk = sat2(r);
         end
      end
   endtask

   task automatic check_reset_outputs();
      @(posedge clk);
      #1;
      check("reset_i_out", bus.i_out, 0);
      check("reset_q_out", bus.q_out, 0);
      check("reset_strobe_out", bus.strobe_out, 0);
   endtask

   // Monitor: pop and compare on every output strobe; flag missing strobes.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (bus.strobe_out === 1'b1) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_strobe: strobe_out=1 at cycle %0d, expected no pending output", cyc);
            end else begin
               e = sb.pop_front();
               check("strobe_cycle", cyc, e.cyc);
               check("i_out", bus.i_out, e.i);
               check("q_out", bus.q_out, e.q);
            end
         end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
            e = sb.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL missing_strobe: strobe_out=0 at cycle %0d, expected 1 at cycle %0d", cyc, e.cyc);
         end
      end
   end

   initial begin
      int r;
      int rates [4] = '{2, 5, 64, 255};
      reset         = 1'b1;
      bus.strobe_in = 1'b0;
      bus.rate      = RW'(4);
      bus.i_in      = '0;
      bus.q_in      = '0;
      model_clear();
      m_rblk = 4;

      // initial reset
      for (int n = 0; n < 3; n++) drive(1, 0, 4, 0, 0);
      check_reset_outputs();

      // DC at R=4, strobe every cycle
      for (int n = 0; n < 60; n++) drive(0, 1, 4, 1000, -1000);
      for (int n = 0; n < 10; n++) drive(0, 0, 4, 0, 0);
      check("t1_settled_i", bus.i_out, 1000);
      check("t1_settled_q", bus.q_out, -1000);

      // full-scale negative DC at R=8, strobe every third cycle
      for (int n = 0; n < 24*12; n++) drive(0, (n % 3) == 0, 8, -524288, -524288);
      for (int n = 0; n < 10; n++) drive(0, 0, 8, 0, 0);
      check("t2_settled_i", bus.i_out, -524288);

      // ratio change 4 -> 16 in the middle of a block
      for (int n = 0; n < 10; n++) drive(0, 1, 4, 1000, 1000);
      for (int n = 0; n < 16*10; n++) drive(0, 1, 16, 1000, 1000);
      for (int n = 0; n < 10; n++) drive(0, 0, 16, 0, 0);
      check("t3_settled_i", bus.i_out, 1000);

      // ratios 0 and 1 behave as 2
      for (int n = 0; n < 120; n++)
         drive(0, $urandom_range(0, 3) != 0, $urandom_range(0, 1), rnd_s(), rnd_s());

      // one-cycle reset in the middle of a block
      for (int n = 0; n < 7; n++) drive(0, 1, 5, 3000, -2000);
      drive(1, 0, 5, 0, 0);
      check_reset_outputs();
      for (int n = 0; n < 40; n++) drive(0, 1, 5, 3000, -2000);

      // random streams at fixed ratios
      foreach (rates[j]) begin
         for (int n = 0; n < rates[j] * 24 + 20; n++)
            drive(0, $urandom_range(0, 3) != 0, rates[j], rnd_s(), rnd_s());
      end

      // random streams with ratio changes at arbitrary points
      r = 5;
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 49) == 0) r = rates[$urandom_range(0, 2)];
         drive(0, $urandom_range(0, 1) == 1, r, rnd_s(), rnd_s());
      end

      for (int n = 0; n < LAT + 10; n++) drive(0, 0, r, 0, 0);
      check("scoreboard_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
